// File: rtl/corefifo_wr_skid.sv
// corefifo_wr_skid: write-side skid-buffered ingress stage for the CoreFIFO controller
// clk/rst            : rising-edge clock, asynchronous active-high reset
// s_valid/s_data     : upstream word and its valid
// s_ready            : registered upstream ready
// fifo_full          : controller full flag, sampled in the write cycle
// fifo_wr_en/fifo_din: write strobe (active-low when WRITE_LOW=1) and data
// busy               : at least one word buffered
// wr_count/clr_count : saturating committed-write count and its synchronous clear
module corefifo_wr_skid #(
    parameter int WWIDTH    = 10,
    parameter int WRITE_LOW = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [WWIDTH-1:0]    s_data,
    output logic                 s_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [WWIDTH-1:0]    fifo_din,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] wr_count,
    input  logic                 clr_count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state, state_n;
    logic [WWIDTH-1:0] out_reg, skid_reg;
    logic push, pop, out_valid;
    assign out_valid  = state != EMPTY;
    assign busy       = out_valid;
    assign push       = s_valid & s_ready;
    assign pop        = out_valid & ~fifo_full;
    assign fifo_wr_en = (WRITE_LOW != 0) ? ~pop : pop;
    assign fifo_din   = out_reg;
    always_comb begin
        state_n = state;
        unique case (state)
            EMPTY:   state_n = push ? ONE : EMPTY;
            ONE:     state_n = (push & ~pop) ? TWO : (~push & pop) ? EMPTY : ONE;
            TWO:     state_n = pop ? ONE : TWO;
            default: state_n = EMPTY;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            s_ready  <= 1'b0;
            out_reg  <= '0;
            skid_reg <= '0;
            wr_count <= '0;
        end else begin
            state   <= state_n;
            s_ready <= state_n != TWO;
            if ((state == EMPTY && push) || (state == ONE && push && pop))
                out_reg <= s_data;
            else if (state == TWO && pop)
                out_reg <= skid_reg;
            if (state == ONE && push && !pop)
                skid_reg <= s_data;
            if (clr_count)
                wr_count <= '0;
            else if (pop && !(&wr_count))
                wr_count <= wr_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_corefifo_wr_skid.sv
// tb_corefifo_wr_skid: directed self-checking bench for corefifo_wr_skid (16-bit and 4-bit counters)
module tb_corefifo_wr_skid;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_valid = 1'b0;
    logic [9:0] s_data = '0;
    logic fifo_full = 1'b0;
    logic clr_count = 1'b0;
    logic s_ready, fifo_wr_en, busy;
    logic s_ready4, fifo_wr_en4, busy4;
    logic [9:0] fifo_din, fifo_din4;
    logic [15:0] wr_count;
    logic [3:0] wr_count4;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    corefifo_wr_skid #(.WWIDTH(10), .WRITE_LOW(1), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .busy(busy), .wr_count(wr_count), .clr_count(clr_count)
    );

    corefifo_wr_skid #(.WWIDTH(10), .WRITE_LOW(1), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready4),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en4), .fifo_din(fifo_din4),
        .busy(busy4), .wr_count(wr_count4), .clr_count(clr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL reset_wr_en got=%b exp=1", fifo_wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL release_pre_edge_s_ready got=%b exp=0", s_ready); end
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL release_s_ready got=%b exp=1", s_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", busy); end
        checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL release_wr_count got=%0d exp=0", wr_count); end
        checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL release_wr_en got=%b exp=1", fifo_wr_en); end
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 10; k++) begin
            s_valid = k < 8;
            s_data = 10'(k + 1);
            @(negedge clk);
            checks++; if (fifo_wr_en !== !(k >= 1 && k <= 8)) begin failures++; $display("FAIL stream_wr_en cyc=%0d got=%b exp=%b", k, fifo_wr_en, !(k >= 1 && k <= 8)); end
            if (k >= 1 && k <= 8) begin
                checks++; if (fifo_din !== 10'(k)) begin failures++; $display("FAIL stream_din cyc=%0d got=%h exp=%h", k, fifo_din, 10'(k)); end
            end
            checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL stream_s_ready cyc=%0d got=%b exp=1", k, s_ready); end
            tick();
        end
        checks++; if (wr_count !== 16'd8) begin failures++; $display("FAIL stream_wr_count got=%0d exp=8", wr_count); end
    endtask

    task automatic test_backpressure();
        fifo_full = 1'b1;
        s_valid = 1'b1;
        s_data = 10'h0A1;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL bp_wr_en_c0 got=%b exp=1", fifo_wr_en); end
        tick();
        s_data = 10'h0A2;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_s_ready_c1 got=%b exp=1", s_ready); end
        checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL bp_wr_en_c1 got=%b exp=1", fifo_wr_en); end
        tick();
        s_valid = 1'b0;
        s_data = 10'h3FF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready_two cyc=%0d got=%b exp=0", k, s_ready); end
            checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL bp_wr_en_two cyc=%0d got=%b exp=1", k, fifo_wr_en); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy_two cyc=%0d got=%b exp=1", k, busy); end
            tick();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL bp_wr_en_first got=%b exp=0", fifo_wr_en); end
        checks++; if (fifo_din !== 10'h0A1) begin failures++; $display("FAIL bp_din_first got=%h exp=0a1", fifo_din); end
        tick();
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_s_ready_after got=%b exp=1", s_ready); end
        checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL bp_wr_en_second got=%b exp=0", fifo_wr_en); end
        checks++; if (fifo_din !== 10'h0A2) begin failures++; $display("FAIL bp_din_second got=%h exp=0a2", fifo_din); end
        tick();
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL bp_wr_en_idle got=%b exp=1", fifo_wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_idle got=%b exp=0", busy); end
        checks++; if (wr_count !== 16'd10) begin failures++; $display("FAIL bp_wr_count got=%0d exp=10", wr_count); end
        tick();
    endtask

    task automatic test_toggle_full();
        int sent = 0;
        int rcv = 0;
        int cyc = 0;
        while ((sent < 20 || rcv < 20) && cyc < 200) begin
            fifo_full = cyc[0];
            s_valid = sent < 20;
            s_data = 10'(12'h100 + sent);
            @(negedge clk);
            if (fifo_wr_en === 1'b0) begin
                checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL toggle_write_while_full cyc=%0d got=1 exp=0", cyc); end
                checks++; if (fifo_din !== 10'(12'h100 + rcv)) begin failures++; $display("FAIL toggle_order idx=%0d got=%h exp=%h", rcv, fifo_din, 10'(12'h100 + rcv)); end
                rcv++;
            end
            if (s_valid && s_ready) sent++;
            cyc++;
            tick();
        end
        checks++; if (cyc >= 200) begin failures++; $display("FAIL toggle_timeout got_sent=%0d got_rcv=%0d exp=20", sent, rcv); end
        s_valid = 1'b0;
        fifo_full = 1'b0;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL toggle_extra_write got=%b exp=1", fifo_wr_en); end
        checks++; if (wr_count !== 16'd30) begin failures++; $display("FAIL toggle_wr_count got=%0d exp=30", wr_count); end
        tick();
    endtask

    task automatic test_saturate_clear();
        checks++; if (wr_count4 !== 4'hF) begin failures++; $display("FAIL sat_wr_count4 got=%h exp=f", wr_count4); end
        s_valid = 1'b1;
        s_data = 10'h3C1;
        tick();
        s_data = 10'h3C2;
        clr_count = 1'b1;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b0 || fifo_din !== 10'h3C1) begin failures++; $display("FAIL clr_pop1 got_en=%b got_din=%h exp_en=0 exp_din=3c1", fifo_wr_en, fifo_din); end
        tick();
        s_valid = 1'b0;
        clr_count = 1'b0;
        checks++; if (wr_count4 !== 4'd0) begin failures++; $display("FAIL clr_wr_count4 got=%0d exp=0", wr_count4); end
        checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL clr_wr_count got=%0d exp=0", wr_count); end
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b0 || fifo_din !== 10'h3C2) begin failures++; $display("FAIL clr_pop2 got_en=%b got_din=%h exp_en=0 exp_din=3c2", fifo_wr_en, fifo_din); end
        tick();
        checks++; if (wr_count4 !== 4'd1) begin failures++; $display("FAIL clr_next_wr_count4 got=%0d exp=1", wr_count4); end
        checks++; if (wr_count !== 16'd1) begin failures++; $display("FAIL clr_next_wr_count got=%0d exp=1", wr_count); end
    endtask

    task automatic test_reset_mid();
        fifo_full = 1'b1;
        s_valid = 1'b1;
        s_data = 10'h055;
        tick();
        s_data = 10'h066;
        tick();
        s_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || s_ready !== 1'b0) begin failures++; $display("FAIL mid_two got_busy=%b got_ready=%b exp_busy=1 exp_ready=0", busy, s_ready); end
        rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_s_ready got=%b exp=0", s_ready); end
        checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL mid_rst_wr_en got=%b exp=1", fifo_wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL mid_rst_wr_count got=%0d exp=0", wr_count); end
        checks++; if (fifo_din !== 10'd0) begin failures++; $display("FAIL mid_rst_din got=%h exp=000", fifo_din); end
        fifo_full = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL mid_release_s_ready got=%b exp=1", s_ready); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL mid_stale_write cyc=%0d got_en=%b got_din=%h exp_en=1", k, fifo_wr_en, fifo_din); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_toggle_full();
        test_saturate_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/corefifo_wr_skid.md
Name: corefifo_wr_skid

Overview:
Write-side ingress stage for the CoreFIFO wrapper. It accepts a valid/ready stream from an upstream producer and drives the FIFO controller's write enable and write data, honouring the controller's full flag. A 2-entry skid buffer keeps upstream ready registered, so there is no combinational path from fifo_full to s_ready. It also maintains a saturating count of committed writes.

Parameters:
WWIDTH, 10, data width of s_data and fifo_din
WRITE_LOW, 1, 1 = fifo_wr_en is active-low; 0 = active-high
CNT_WIDTH, 16, width of wr_count

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
s_valid  input  1  upstream word valid
s_data  input  WWIDTH  upstream word
s_ready  output  1  upstream may present a word; registered
fifo_full  input  1  FIFO controller full flag, active-high
fifo_wr_en  output  1  write strobe to FIFO controller; polarity per WRITE_LOW
fifo_din  output  WWIDTH  write data to FIFO controller
busy  output  1  buffer holds at least one word
wr_count  output  CNT_WIDTH  saturating count of committed writes
clr_count  input  1  synchronous clear of wr_count

Behaviour:
- Definitions: push = s_valid & s_ready. pop = out_valid & !fifo_full. fifo_wr_en asserted (per WRITE_LOW) exactly when pop.
- fifo_din = out_reg at all times. It holds its value when not popping.
- Occupancy FSM has three states: EMPTY, ONE, TWO.
- EMPTY, push: out_reg <= s_data; go to ONE.
- ONE:
  - push & pop: out_reg <= s_data; stay in ONE.
  - push & !pop: skid_reg <= s_data; go to TWO.
  - !push & pop: go to EMPTY.
  - otherwise: hold.
- TWO (push impossible):
  - pop: out_reg <= skid_reg; go to ONE.
  - otherwise: hold.
- out_valid = (state != EMPTY). busy = out_valid.
- s_ready is a flop. Next value = 1 unless next state is TWO.
- Latency: a word accepted at edge N is presented on fifo_wr_en/fifo_din in cycle N+1, earliest.
- Throughput: 1 word/clk sustained while fifo_full=0.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- fifo_full is sampled combinationally in the same cycle as the write. A write is never issued while fifo_full=1.
- fifo_full may toggle every cycle. In ONE or TWO with fifo_full=1, out_reg and skid_reg hold.
- wr_count increments on every pop and saturates at all-ones; no wrap.
- clr_count has priority over a same-cycle pop: count becomes 0 and that pop is not counted.
- Reset (asynchronous, any time including mid-transfer):
  - state = EMPTY; out_reg and skid_reg = 0; wr_count = 0.
  - s_ready = 0; fifo_wr_en inactive (1 if WRITE_LOW=1, else 0); busy = 0.
  - Buffered words are discarded.
- s_ready rises on the first clk edge after rst deasserts.
- s_data is don't-care when s_valid=0. Upstream must hold s_valid/s_data stable until push.

Test Plan:
- Reset release, WRITE_LOW=1: during rst, s_ready=0 and fifo_wr_en=1. First edge after release: s_ready=1, busy=0, wr_count=0.
- Streaming: fifo_full=0, push 0x001..0x008 on consecutive clocks. fifo_wr_en active for 8 consecutive cycles starting 1 cycle after the first push, fifo_din=0x001..0x008 in order, s_ready stays 1, wr_count=8.
- Backpressure: push 0x0A1, 0x0A2 with fifo_full=1. State goes to TWO, s_ready=0 the cycle after the second push, fifo_wr_en inactive. Drop fifo_full: 0x0A1 then 0x0A2 written on consecutive cycles, s_ready=1 after the first write.
- Toggling full: s_valid=1 continuously, fifo_full alternating 1/0 every cycle, 20 words sent. All 20 written in order, none lost or duplicated, wr_count=20, no write while fifo_full=1.
- Saturation/clear: CNT_WIDTH=4, 20 writes, then wr_count=0xF. Assert clr_count in a pop cycle: wr_count=0 next cycle, and the following pop gives 1.
- Reset mid-operation: in state TWO holding 0x055, 0x066, pulse rst asynchronously between edges. Outputs go to their reset values immediately, and after release no write of 0x055 or 0x066 occurs.
